des_decrypt_core: RTL and testbench



---
 rtl/des_pkg.sv | 71 +++++++
 rtl/des_decrypt_core_if.sv | 22 ++
 rtl/des_decrypt_core_f_function.sv | 75 +++++++
 rtl/des_decrypt_core.sv | 121 ++++++++++++
 tb/tb_des_decrypt_core.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: permutation index tables, decryption key-rotation tables,
// FSM state type and permutation helpers used by the decryption core.
package des_pkg;

   typedef enum logic [1:0] {StIdle, StRound, StDone} des_state_e;

   localparam int unsigned NumRounds = 16;

   // Each entry is the DES bit number (1 = MSB of the source) feeding that output, MSB first.
   localparam int unsigned IpTbl [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

   localparam int unsigned FpTbl [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

   localparam int unsigned Pc1Tbl [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int unsigned Pc2Tbl [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // Right rotation of C and D after round index rnd. The final zero leaves C||D at C1||D1.
   localparam logic [4:0] RotR1Tbl [16] = '{
      5'd1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd1,
      5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd1, 5'd0};

   // Pairwise sums of RotR1Tbl, indexed by rnd/2.
   localparam logic [4:0] RotR2Tbl [8] = '{
      5'd3, 5'd4, 5'd4, 5'd3, 5'd4, 5'd4, 5'd4, 5'd1};

   function automatic logic [63:0] des_ip(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[6'(63 - i)] = x[6'(64 - IpTbl[6'(i)])];
      return r;
   endfunction

   function automatic logic [63:0] des_fp(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[6'(63 - i)] = x[6'(64 - FpTbl[6'(i)])];
      return r;
   endfunction

   function automatic logic [55:0] des_pc1(input logic [63:0] x);
      logic [55:0] r;
      for (int i = 0; i < 56; i++) r[6'(55 - i)] = x[6'(64 - Pc1Tbl[6'(i)])];
      return r;
   endfunction

   function automatic logic [47:0] des_pc2(input logic [55:0] x);
      logic [47:0] r;
      for (int i = 0; i < 48; i++) r[6'(47 - i)] = x[6'(56 - Pc2Tbl[6'(i)])];
      return r;
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [4:0] n);
      return (x >> n) | (x << (5'd28 - n));
   endfunction

endpackage

// File: rtl/des_decrypt_core_if.sv
// Handshake and data bundle between the input filter, the DES decryption core and the
// data-compare logic. master drives blocks in and accepts plaintext; slave is the core.
interface des_decrypt_core_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] key;
   logic [63:0] cipher;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] plain;
   logic        busy;

   modport master (
      output in_valid, key, cipher, out_ready,
      input  in_ready, out_valid, plain, busy
   );

   modport slave (
      input  in_valid, key, cipher, out_ready,
      output in_ready, out_valid, plain, busy
   );
endinterface

// File: rtl/des_decrypt_core_f_function.sv
// DES round function F: expansion E, key mix, S-boxes S1..S8, permutation P.
module F_function (
   input  logic [47:0] key,
   input  logic [31:0] F_in,
   output logic [31:0] F_out
);

   localparam int unsigned ETbl [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int unsigned PTbl [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   // Indexed by {row, column} = {b[5], b[0], b[4:1]}.
   localparam int unsigned SBox [8][64] = '{
      '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
      '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
      '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
      '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
      '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
      '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
      '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
      '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

   logic [47:0] xk;
   logic [31:0] s_out;

   // Expansion followed by key mix
   always_comb begin
      xk = '0;
      for (int i = 0; i < 48; i++) xk[6'(47 - i)] = F_in[5'(32 - ETbl[6'(i)])];
      xk = xk ^ key;
   end

   for (genvar g = 0; g < 8; g++) begin : g_sbox
      logic [5:0] b;
      assign b = xk[47 - 6*g -: 6];
      assign s_out[31 - 4*g -: 4] = 4'(SBox[g][{b[5], b[0], b[4:1]}]);
   end

   // Output permutation P
   always_comb begin
      F_out = '0;
      for (int i = 0; i < 32; i++) F_out[5'(31 - i)] = s_out[5'(32 - PTbl[5'(i)])];
   end

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core: 16 Feistel rounds with subkeys K16..K1 produced by
// right-rotating C/D on the fly. Optional macro DES_DEC_UNROLL2_EN runs two rounds per cycle.
module des_decrypt_core
   import des_pkg::*;
(
   input logic               clk,
   input logic               rst,
   des_decrypt_core_if.slave bus_io
);

   des_state_e  state_q;
   logic [4:0]  rnd_q;
   logic [31:0] l_q, r_q;
   logic [27:0] c_q, d_q;
   logic        in_ready_q, out_valid_q, busy_q;
   logic [63:0] plain_q;

   logic [47:0] k1;
   logic [31:0] f1, r_mid;
   logic [31:0] l_d, r_d;
   logic [27:0] c_d, d_d;

   assign k1    = des_pc2({c_q, d_q});
   assign r_mid = l_q ^ f1;

   F_function u_f1 (
      .key  (k1),
      .F_in (r_q),
      .F_out(f1)
   );

`ifdef DES_DEC_UNROLL2_EN
   localparam logic [4:0] RndStep = 5'd2;
   localparam logic [4:0] LastRnd = 5'(NumRounds - 2);

   logic [27:0] c_mid, d_mid;
   logic [47:0] k2;
   logic [31:0] f2;

   // Second round of the pair uses C/D after the single-round rotation of the first
   assign c_mid = rotr28(c_q, RotR1Tbl[rnd_q[3:0]]);
   assign d_mid = rotr28(d_q, RotR1Tbl[rnd_q[3:0]]);
   assign k2    = des_pc2({c_mid, d_mid});

   F_function u_f2 (
      .key  (k2),
      .F_in (r_mid),
      .F_out(f2)
   );

   assign l_d = r_mid;
   assign r_d = r_q ^ f2;
   assign c_d = rotr28(c_q, RotR2Tbl[rnd_q[3:1]]);
   assign d_d = rotr28(d_q, RotR2Tbl[rnd_q[3:1]]);
`else
   localparam logic [4:0] RndStep = 5'd1;
   localparam logic [4:0] LastRnd = 5'(NumRounds - 1);

   assign l_d = r_q;
   assign r_d = r_mid;
   assign c_d = rotr28(c_q, RotR1Tbl[rnd_q[3:0]]);
   assign d_d = rotr28(d_q, RotR1Tbl[rnd_q[3:0]]);
`endif

   // Control FSM with registered handshake outputs and plaintext
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rnd_q       <= '0;
         l_q         <= '0;
         r_q         <= '0;
         c_q         <= '0;
         d_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         plain_q     <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus_io.in_valid && in_ready_q) begin
                  {l_q, r_q} <= des_ip(bus_io.cipher);
                  {c_q, d_q} <= des_pc1(bus_io.key);
                  rnd_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= StRound;
               end
            end
            StRound: begin
               l_q   <= l_d;
               r_q   <= r_d;
               c_q   <= c_d;
               d_q   <= d_d;
               rnd_q <= rnd_q + RndStep;
               if (rnd_q == LastRnd) begin
                  // Final output swaps halves: FP(R16 || L16)
                  plain_q     <= des_fp({r_d, l_d});
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (bus_io.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.in_ready  = in_ready_q;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.plain     = plain_q;
   assign bus_io.busy      = busy_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Scoreboard bench for des_decrypt_core: driver pushes expected plaintext and handshake
// cycle; a negedge monitor checks latency, value and stability of every output.
module tb_des_decrypt_core;

`ifdef DES_DEC_UNROLL2_EN
   localparam int Lat = 9;
`else
   localparam int Lat = 17;
`endif
   localparam int Period = Lat + 1;

   localparam logic [63:0] K1 = 64'h1334_5779_9BBC_DFF1;
   localparam logic [63:0] C1 = 64'h85E8_1354_0F0A_B405;
   localparam logic [63:0] P1 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] K2 = 64'h0E32_9232_EA6D_0D73;
   localparam logic [63:0] C2 = 64'h0000_0000_0000_0000;
   localparam logic [63:0] P2 = 64'h8787_8787_8787_8787;

   typedef struct {
      logic [63:0] plain;
      int          hs_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_checks = 0;
   int   n_err = 0;
   exp_t sb_q[$];
   logic ov_prev = 1'b0;

   des_decrypt_core_if dut_if ();

   des_decrypt_core u_dut (
      .clk   (clk),
      .rst   (rst),
      .bus_io(dut_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] k, input logic [63:0] c, input logic [63:0] p,
                       output int hs);
      int t = 0;
      while (!dut_if.in_ready && t < 100) begin
         step();
         t++;
      end
      if (!dut_if.in_ready) check("in_ready_timeout", 64'(dut_if.in_ready), 64'd1);
      dut_if.in_valid = 1'b1;
      dut_if.key      = k;
      dut_if.cipher   = c;
      hs              = cyc;
      sb_q.push_back('{plain: p, hs_cyc: cyc});
      n_vec++;
      step();
      dut_if.in_valid = 1'b0;
      dut_if.key      = ~k;
      dut_if.cipher   = ~c;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((sb_q.size() != 0 || !dut_if.in_ready) && t < 200) begin
         step();
         t++;
      end
      check("drain_timeout", 64'(sb_q.size()), 64'd0);
   endtask

   // Monitor: latency on out_valid rise, value every valid cycle, pop on acceptance
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (dut_if.out_valid && !ov_prev) begin
            if (sb_q.size() == 0) check("unexpected_out_valid", 64'(dut_if.out_valid), 64'd0);
            else check("latency", 64'(cyc - sb_q[0].hs_cyc), 64'(Lat));
         end
         if (dut_if.out_valid && sb_q.size() != 0) check("plain", dut_if.plain, sb_q[0].plain);
         if (dut_if.out_valid && dut_if.out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
      end
      ov_prev = dut_if.out_valid;
   end

   initial begin
      int hs, hs2;
      rst              = 1'b1;
      dut_if.in_valid  = 1'b0;
      dut_if.key       = '0;
      dut_if.cipher    = '0;
      dut_if.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready", 64'(dut_if.in_ready), 64'd1);
      check("rst_out_valid", 64'(dut_if.out_valid), 64'd0);
      check("rst_busy", 64'(dut_if.busy), 64'd0);
      check("rst_plain", dut_if.plain, 64'd0);

      // Basic decrypt
      send(K1, C1, P1, hs);
      wait_idle();

      // Second vector; in_ready low and busy high for cycles 1..Lat
      send(K2, C2, P2, hs);
      for (int i = 1; i <= Lat; i++) begin
         check("in_ready_busy_phase", 64'(dut_if.in_ready), 64'd0);
         check("busy_phase", 64'(dut_if.busy), 64'd1);
         step();
      end
      check("in_ready_after_accept", 64'(dut_if.in_ready), 64'd1);
      wait_idle();

      // Back-pressure in DONE
      dut_if.out_ready = 1'b0;
      send(K1, C1, P1, hs);
      for (int t = 0; t < 40 && !dut_if.out_valid; t++) step();
      check("bp_out_valid_seen", 64'(dut_if.out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_out_valid_hold", 64'(dut_if.out_valid), 64'd1);
         check("bp_plain_hold", dut_if.plain, P1);
         check("bp_in_ready_low", 64'(dut_if.in_ready), 64'd0);
      end
      dut_if.out_ready = 1'b1;
      step();
      check("bp_in_ready_next", 64'(dut_if.in_ready), 64'd1);
      check("bp_out_valid_drop", 64'(dut_if.out_valid), 64'd0);
      wait_idle();

      // Input hold-off: pulse in_valid with other data during ROUND
      send(K1, C1, P1, hs);
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         dut_if.in_valid = 1'b1;
         dut_if.key      = K2 ^ 64'(i);
         dut_if.cipher   = C2 + 64'(i * 7);
         step();
      end
      dut_if.in_valid = 1'b0;
      wait_idle();
      repeat (Lat + 3) step();

      // Mid-operation reset at cycle 7, then a fresh block
      send(K2, C2, P2, hs);
      repeat (6) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      void'(sb_q.pop_back());
      check("mid_rst_out_valid", 64'(dut_if.out_valid), 64'd0);
      check("mid_rst_plain", dut_if.plain, 64'd0);
      check("mid_rst_in_ready", 64'(dut_if.in_ready), 64'd1);
      check("mid_rst_busy", 64'(dut_if.busy), 64'd0);
      send(K2, C2, P2, hs);
      wait_idle();

      // Back-to-back with out_ready held high
      send(K1, C1, P1, hs);
      send(K2, C2, P2, hs2);
      check("b2b_spacing", 64'(hs2 - hs), 64'(Period));
      wait_idle();
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
